mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised memory-access pipeline stage for the RISC-V core, sitting between the EX_MEM and MEM_WB latches. Register-only instructions pass straight through in the same cycle. Loads and stores are serialised into byte transfers on a req/ack port to the memory controller, with `memStall_out` held high until the access completes. Load results are assembled, then sign- or zero-extended to XLEN.

## Interface
Parameters:
- `DATA_BYTES`, default 4: XLEN = 8*DATA_BYTES. Must be 4 or 8.
- `ADDR_WIDTH`, default 32: width of `memAddr_in` and `memAddr_out`.

Ports:
- `clk_in`  in  1: clock. One clock domain; all state updates on its rising edge.
- `rst_in`  in  1: reset. Synchronous, active-high.
- `rdE_in`  in  1: destination write enable from EX_MEM.
- `rdIdx_in`  in  5: destination register index.
- `rdData_in`  in  XLEN: ALU result for non-memory instructions.
- `memLoad_in`  in  1: instruction is a load.
- `memStore_in`  in  1: instruction is a store. Never high together with `memLoad_in`.
- `memFunct3_in`  in  3: bits [1:0] = log2 of access size in bytes; bit 2 = unsigned (loads only).
- `memAddr_in`  in  ADDR_WIDTH: effective address.
- `storeData_in`  in  XLEN: store data.
- `rdE_out`  out  1: to MEM_WB.
- `rdIdx_out`  out  5: to MEM_WB.
- `rdData_out`  out  XLEN: to MEM_WB.
- `memStall_out`  out  1: stall request to the hazard/stall controller.
- `memMisalign_out`  out  1: misaligned-access flag, one cycle wide.
- `memReq_out`  out  1: byte transfer request to the memory controller.
- `memWr_out`  out  1: 1 = write, 0 = read.
- `memAddrOut_out`  out  ADDR_WIDTH: byte address of the current transfer.
- `memWData_out`  out  8: write byte.
- `memRData_in`  in  8: read byte, valid in the cycle `memAck_in` is high.
- `memAck_in`  in  1: current byte transfer has completed.

## Operation
- FSM states: IDLE, ACCESS, DONE. Byte counter `cnt`. Load buffer `buf` of XLEN bits.
- Access size N = 1 << `memFunct3_in`[1:0].
  - If N > DATA_BYTES, the access is illegal: no transfer is issued, `rdE_out`=0, no stall.
- IDLE, no memory operation:
  - `rdE_out`/`rdIdx_out`/`rdData_out` follow the inputs combinationally; `memStall_out`=0.
- IDLE, load or store:
  - `memStall_out`=1 combinationally.
  - Next state ACCESS; `cnt` is cleared to 0 and `buf` to 0.
- ACCESS:
  - `memReq_out`=1; `memAddrOut_out` = `memAddr_in` + `cnt` (wraps modulo 2^ADDR_WIDTH); `memWr_out` = `memStore_in`; `memWData_out` = `storeData_in` byte `cnt` (little-endian).
  - On `memAck_in`: for a load, `buf` byte `cnt` ← `memRData_in`. If `cnt` == N-1, go to DONE; otherwise `cnt`++.
  - `memStall_out`=1 throughout ACCESS.
  - No ack means the FSM waits indefinitely, with request outputs held stable.
- DONE:
  - `memStall_out`=0, `memReq_out`=0.
  - Load: `rdE_out`=`rdE_in`, `rdIdx_out`=`rdIdx_in`, `rdData_out` = `buf` low N bytes, sign-extended if `memFunct3_in`[2]=0, else zero-extended.
  - Store: `rdE_out`=0.
  - Next state is IDLE unconditionally. This prevents re-issue while EX_MEM advances.
- `memAck_in` is ignored outside ACCESS.
- EX_MEM inputs are held stable by the stall for the whole access. The block does not latch them.

## Timing
- Non-memory instruction: 0 added cycles.
- N-byte access with ack in the same cycle as each request: stall high for N+1 cycles (1 IDLE + N ACCESS), result in the DONE cycle. Total occupancy is N+2 cycles.
- Reset, including mid-access: next state IDLE; `cnt`=0, `buf`=0; `memReq_out`, `memWr_out`, `memWData_out`, `memAddrOut_out` = 0.
- While `rst_in` is high, combinational outputs are forced as follows: `rdE_out`=0, `rdIdx_out`=0, `rdData_out`=0, `memStall_out`=0, `memMisalign_out`=0.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - In IDLE, a load or store with `memAddr_in` mod N ≠ 0 issues no transfer and stays in IDLE.
  - Outputs that cycle: `memStall_out`=0, `memMisalign_out`=1, `rdE_out`=0.
- `MEM_MISALIGN_CHECK_EN` undefined:
  - `memMisalign_out` is tied to 0.
  - Misaligned accesses proceed byte-serially at consecutive addresses, crossing word boundaries transparently.

## Test plan
- Pass-through: `rdE_in`=1, `rdIdx_in`=5, `rdData_in`=0x1234 with no memory operation → same cycle `rdE_out`=1, `rdIdx_out`=5, `rdData_out`=0x1234, stall 0.
- LB at 0x100 with `memRData_in`=0x80 and immediate ack → stall for 2 cycles, one request to 0x100, DONE `rdData_out`=0xFFFFFF80. LBU of the same byte → 0x00000080.
- SW of 0xAABBCCDD at 0x200, ack every cycle → writes DD, CC, BB, AA to 0x200–0x203, stall for 5 cycles, DONE `rdE_out`=0.
- LW at 0x300 with ack delayed 3 cycles per byte → address and request stay stable while waiting, `cnt` advances only on ack, result 0x44332211 from bytes 11, 22, 33, 44.
- `rst_in` asserted during the third byte of an LW → next cycle IDLE, `memReq_out`=0, stall 0. A subsequent LW completes correctly.
- LH at 0x101:
  - With `MEM_MISALIGN_CHECK_EN`: `memMisalign_out`=1 for one cycle, no request issued.
  - Without it: reads 0x101 and 0x102, returning the sign-extended half-word.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Byte-serial request/acknowledge bus between the memory-access stage and the
// memory controller. The stage drives the request side through the master modport.
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  memReq_out;
  logic                  memWr_out;
  logic [ADDR_WIDTH-1:0] memAddrOut_out;
  logic [7:0]            memWData_out;
  logic [7:0]            memRData_in;
  logic                  memAck_in;

  modport master (
    output memReq_out, memWr_out, memAddrOut_out, memWData_out,
    input  memRData_in, memAck_in
  );

  modport slave (
    input  memReq_out, memWr_out, memAddrOut_out, memWData_out,
    output memRData_in, memAck_in
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: register results pass through, loads/stores become byte transfers.
// Define MEM_MISALIGN_CHECK_EN to reject accesses not aligned to their own size.
module mem_access_stage #(
  parameter  int DATA_BYTES = 4,
  parameter  int ADDR_WIDTH = 32,
  localparam int XLEN       = 8 * DATA_BYTES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdE_in,
  input  logic [4:0]            rdIdx_in,
  input  logic [XLEN-1:0]       rdData_in,
  input  logic                  memLoad_in,
  input  logic                  memStore_in,
  input  logic [2:0]            memFunct3_in,
  input  logic [ADDR_WIDTH-1:0] memAddr_in,
  input  logic [XLEN-1:0]       storeData_in,
  output logic                  rdE_out,
  output logic [4:0]            rdIdx_out,
  output logic [XLEN-1:0]       rdData_out,
  output logic                  memStall_out,
  output logic                  memMisalign_out,
  mem_access_stage_if.master    mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [XLEN-1:0] load_buf;
  logic [XLEN-1:0] load_ext;

  logic [3:0] size;
  logic [2:0] next_cnt;
  logic       mem_op;
  logic       illegal;
  logic       misaligned;
  logic       start;
  logic       last;

  assign size     = 4'd1 << memFunct3_in[1:0];
  assign mem_op   = memLoad_in | memStore_in;
  assign illegal  = size > 4'(DATA_BYTES);
  assign next_cnt = cnt + 3'd1;
  assign last     = (cnt == 3'(size - 4'd1));

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = |(memAddr_in[2:0] & 3'(size - 4'd1));
`else
  assign misaligned = 1'b0;
`endif

  assign start = mem_op & ~illegal & ~misaligned;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: load_buf is a small register, not a memory array, so it is
      // reset like any other state to keep reset values deterministic.
      state              <= IDLE;
      cnt                <= '0;
      load_buf           <= '0;
      mem.memReq_out     <= 1'b0;
      mem.memWr_out      <= 1'b0;
      mem.memAddrOut_out <= '0;
      mem.memWData_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state              <= ACCESS;
            cnt                <= '0;
            load_buf           <= '0;
            mem.memReq_out     <= 1'b1;
            mem.memWr_out      <= memStore_in;
            mem.memAddrOut_out <= memAddr_in;
            mem.memWData_out   <= storeData_in[7:0];
          end
        end
        ACCESS: begin
          // Request outputs are registered, so they stay frozen until an ack.
          if (mem.memAck_in) begin
            if (memLoad_in) load_buf[8*int'(cnt) +: 8] <= mem.memRData_in;
            if (last) begin
              state          <= DONE;
              mem.memReq_out <= 1'b0;
              mem.memWr_out  <= 1'b0;
            end else begin
              cnt                <= next_cnt;
              mem.memAddrOut_out <= memAddr_in + ADDR_WIDTH'(next_cnt);
              mem.memWData_out   <= storeData_in[8*int'(next_cnt) +: 8];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic sign;
    sign = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++)
      if (i == int'(size) - 1) sign = load_buf[8*i+7];
    for (int i = 0; i < DATA_BYTES; i++)
      load_ext[8*i +: 8] = (i < int'(size)) ? load_buf[8*i +: 8]
                                            : {8{sign & ~memFunct3_in[2]}};
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdE_out         = 1'b0;
    rdIdx_out       = '0;
    rdData_out      = '0;
    memStall_out    = 1'b0;
    memMisalign_out = 1'b0;
    if (!rst_in) begin
      case (state)
        IDLE: begin
          rdIdx_out  = rdIdx_in;
          rdData_out = rdData_in;
          if (!mem_op)          rdE_out         = rdE_in;
          else if (illegal)     rdE_out         = 1'b0;
          else if (misaligned)  memMisalign_out = 1'b1;
          else                  memStall_out    = 1'b1;
        end
        ACCESS: begin
          rdIdx_out    = rdIdx_in;
          memStall_out = 1'b1;
        end
        DONE: begin
          rdIdx_out = rdIdx_in;
          if (memLoad_in) begin
            rdE_out    = rdE_in;
            rdData_out = load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: acts as the byte memory controller
// and compares against a byte-array memory model with arithmetic load assembly.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdE_in;
  logic [4:0]  rdIdx_in;
  logic [31:0] rdData_in;
  logic        memLoad_in;
  logic        memStore_in;
  logic [2:0]  memFunct3_in;
  logic [31:0] memAddr_in;
  logic [31:0] storeData_in;
  logic        rdE_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;
  logic        memStall_out;
  logic        memMisalign_out;

  mem_access_stage_if #(.ADDR_WIDTH(32)) bus ();

  mem_access_stage #(.DATA_BYTES(4), .ADDR_WIDTH(32)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rdE_in          (rdE_in),
    .rdIdx_in        (rdIdx_in),
    .rdData_in       (rdData_in),
    .memLoad_in      (memLoad_in),
    .memStore_in     (memStore_in),
    .memFunct3_in    (memFunct3_in),
    .memAddr_in      (memAddr_in),
    .storeData_in    (storeData_in),
    .rdE_out         (rdE_out),
    .rdIdx_out       (rdIdx_out),
    .rdData_out      (rdData_out),
    .memStall_out    (memStall_out),
    .memMisalign_out (memMisalign_out),
    .mem             (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Byte-addressed memory behind the controller; unwritten bytes read a pattern.
  logic [7:0] mem_model [int unsigned];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mem_rd(a + 32'(i))) << (8 * i));
    if (!f3[2] && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v[31:0];
  endfunction

  // Results of the most recent run_op.
  int          stall_cycles;
  int          wait_bad;
  bit          timed_out;
  logic [31:0] res_data;
  logic        res_rde;
  logic        res_mis;
  logic [31:0] obs_addr [$];
  logic [7:0]  obs_wdata [$];

  // Presents one instruction and serves byte transfers, acking each request
  // after dly idle cycles, until the stall drops. Starts and ends at posedge+1.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input int dly);
    int waited;
    bit done;
    logic [31:0] held_addr;
    obs_addr.delete();
    obs_wdata.delete();
    stall_cycles = 0;
    wait_bad     = 0;
    timed_out    = 1'b0;
    waited       = 0;
    done         = 1'b0;
    held_addr    = '0;
    memLoad_in   = ld;
    memStore_in  = st;
    memFunct3_in = f3;
    memAddr_in   = addr;
    storeData_in = sd;
    rdE_in       = 1'b1;
    rdIdx_in     = 5'($urandom);
    rdData_in    = $urandom;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (bus.memReq_out) begin
        if (waited > 0 && bus.memAddrOut_out !== held_addr) wait_bad++;
        held_addr = bus.memAddrOut_out;
        if (waited < dly) begin
          bus.memAck_in = 1'b0;
          waited++;
        end else begin
          bus.memAck_in = 1'b1;
          waited = 0;
          obs_addr.push_back(bus.memAddrOut_out);
          if (bus.memWr_out) begin
            obs_wdata.push_back(bus.memWData_out);
            mem_model[bus.memAddrOut_out] = bus.memWData_out;
          end else begin
            bus.memRData_in = mem_rd(bus.memAddrOut_out);
          end
        end
      end else begin
        if (waited > 0) wait_bad++;
        bus.memAck_in   = 1'($urandom_range(0, 1));
        bus.memRData_in = 8'($urandom);
      end
      #1;
      if (memStall_out) stall_cycles++;
      else begin
        res_data = rdData_out;
        res_rde  = rdE_out;
        res_mis  = memMisalign_out;
        done     = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) timed_out = 1'b1;
    memLoad_in    = 1'b0;
    memStore_in   = 1'b0;
    bus.memAck_in = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    rdE_in       = 1'b1;
    rdIdx_in     = 5'd7;
    rdData_in    = 32'hDEAD_BEEF;
    memLoad_in   = 1'b1;
    memStore_in  = 1'b0;
    memFunct3_in = 3'b010;
    memAddr_in   = 32'h40;
    storeData_in = '0;
    bus.memAck_in   = 1'b0;
    bus.memRData_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdE_out, rdIdx_out, rdData_out, memStall_out, memMisalign_out} !== 39'd0) begin
      errors++;
      $display("FAIL reset_comb: got rdE=%b idx=%0d data=%h stall=%b mis=%b expected all zero",
               rdE_out, rdIdx_out, rdData_out, memStall_out, memMisalign_out);
    end
    checks++;
    if ({bus.memReq_out, bus.memWr_out, bus.memAddrOut_out, bus.memWData_out} !== 42'd0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b wr=%b addr=%h wdata=%h expected all zero",
               bus.memReq_out, bus.memWr_out, bus.memAddrOut_out, bus.memWData_out);
    end
    memLoad_in = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 7; i++) begin
      rdE_in    = (i == 0) ? 1'b1 : 1'($urandom);
      rdIdx_in  = (i == 0) ? 5'd5 : 5'($urandom);
      rdData_in = (i == 0) ? 32'h1234 : $urandom;
      #1;
      checks++;
      if ({rdE_out, rdIdx_out, rdData_out, memStall_out} !== {rdE_in, rdIdx_in, rdData_in, 1'b0}) begin
        errors++;
        $display("FAIL passthrough[%0d]: got rdE=%b idx=%0d data=%h stall=%b expected rdE=%b idx=%0d data=%h stall=0",
                 i, rdE_out, rdIdx_out, rdData_out, memStall_out, rdE_in, rdIdx_in, rdData_in);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lb();
    mem_model[32'h100] = 8'h80;
    for (int u = 0; u < 2; u++) begin
      run_op(1'b1, 1'b0, (u == 0) ? 3'b000 : 3'b100, 32'h100, '0, 0);
      checks++;
      if (timed_out || stall_cycles != 2 || obs_addr.size() != 1) begin
        errors++;
        $display("FAIL lb_timing[%0d]: got stall=%0d reqs=%0d timeout=%b expected stall=2 reqs=1",
                 u, stall_cycles, obs_addr.size(), timed_out);
      end else if (obs_addr[0] !== 32'h100) begin
        errors++;
        $display("FAIL lb_addr[%0d]: got %h expected 00000100", u, obs_addr[0]);
      end
      checks++;
      if (res_data !== ((u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080) || res_rde !== 1'b1) begin
        errors++;
        $display("FAIL lb_data[%0d]: got %h rdE=%b expected %h rdE=1",
                 u, res_data, res_rde, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      end
    end
  endtask

  task automatic test_sw();
    logic [31:0] want = 32'hAABB_CCDD;
    bit bad = 1'b0;
    run_op(1'b0, 1'b1, 3'b010, 32'h200, want, 0);
    checks++;
    if (timed_out || stall_cycles != 5 || res_rde !== 1'b0) begin
      errors++;
      $display("FAIL sw_timing: got stall=%0d rdE=%b timeout=%b expected stall=5 rdE=0",
               stall_cycles, res_rde, timed_out);
    end
    if (obs_wdata.size() != 4 || obs_addr.size() != 4) bad = 1'b1;
    else
      for (int i = 0; i < 4; i++)
        if (obs_addr[i] !== 32'h200 + 32'(i) || obs_wdata[i] !== want[8*i +: 8]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL sw_bytes: got %0d writes (first addr %h data %h) expected DD,CC,BB,AA at 200..203",
               obs_wdata.size(), (obs_addr.size() > 0) ? obs_addr[0] : 32'hx,
               (obs_wdata.size() > 0) ? obs_wdata[0] : 8'hx);
    end
  endtask

  task automatic test_lw_delay();
    mem_model[32'h300] = 8'h11;
    mem_model[32'h301] = 8'h22;
    mem_model[32'h302] = 8'h33;
    mem_model[32'h303] = 8'h44;
    run_op(1'b1, 1'b0, 3'b010, 32'h300, '0, 3);
    checks++;
    if (timed_out || stall_cycles != 17 || wait_bad != 0) begin
      errors++;
      $display("FAIL lw_delay_timing: got stall=%0d unstable=%0d timeout=%b expected stall=17 unstable=0",
               stall_cycles, wait_bad, timed_out);
    end
    checks++;
    if (res_data !== 32'h4433_2211) begin
      errors++;
      $display("FAIL lw_delay_data: got %h expected 44332211", res_data);
    end
  endtask

  task automatic test_reset_mid();
    int acked = 0;
    bit hit = 1'b0;
    memLoad_in   = 1'b1;
    memStore_in  = 1'b0;
    memFunct3_in = 3'b010;
    memAddr_in   = 32'h300;
    rdE_in       = 1'b1;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      if (bus.memReq_out && acked == 2) begin
        hit = 1'b1;
      end else begin
        bus.memAck_in   = bus.memReq_out;
        bus.memRData_in = mem_rd(bus.memAddrOut_out);
        if (bus.memReq_out) acked++;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!hit || bus.memAddrOut_out !== 32'h302) begin
      errors++;
      $display("FAIL rst_mid_setup: got reached=%b addr=%h expected third byte at 00000302",
               hit, bus.memAddrOut_out);
    end
    bus.memAck_in = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (memStall_out !== 1'b0 || rdE_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_forced: got stall=%b rdE=%b expected 0 0", memStall_out, rdE_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    memLoad_in = 1'b0;
    #1;
    checks++;
    if (bus.memReq_out !== 1'b0 || memStall_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: got req=%b stall=%b expected 0 0", bus.memReq_out, memStall_out);
    end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 3'b010, 32'h300, '0, 0);
    checks++;
    if (timed_out || res_data !== 32'h4433_2211 || stall_cycles != 5) begin
      errors++;
      $display("FAIL rst_mid_after: got data=%h stall=%0d expected 44332211 stall=5",
               res_data, stall_cycles);
    end
  endtask

  task automatic test_misalign();
    mem_model[32'h101] = 8'h34;
    mem_model[32'h102] = 8'hF2;
    run_op(1'b1, 1'b0, 3'b001, 32'h101, '0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++;
    if (timed_out || stall_cycles != 0 || res_mis !== 1'b1 || res_rde !== 1'b0 || obs_addr.size() != 0) begin
      errors++;
      $display("FAIL misalign_flag: got stall=%0d mis=%b rdE=%b reqs=%0d expected 0 1 0 0",
               stall_cycles, res_mis, res_rde, obs_addr.size());
    end
    #1;
    checks++;
    if (memMisalign_out !== 1'b0 || bus.memReq_out !== 1'b0) begin
      errors++;
      $display("FAIL misalign_width: got mis=%b req=%b next cycle expected 0 0",
               memMisalign_out, bus.memReq_out);
    end
`else
    checks++;
    if (timed_out || stall_cycles != 3 || obs_addr.size() != 2 ||
        obs_addr[0] !== 32'h101 || obs_addr[1] !== 32'h102 || res_mis !== 1'b0) begin
      errors++;
      $display("FAIL misalign_access: got stall=%0d reqs=%0d mis=%b expected stall=3 reqs at 101,102 mis=0",
               stall_cycles, obs_addr.size(), res_mis);
    end
    checks++;
    if (res_data !== 32'hFFFF_F234) begin
      errors++;
      $display("FAIL misalign_data: got %h expected fffff234", res_data);
    end
`endif
  endtask

  task automatic test_illegal();
    run_op(1'b1, 1'b0, 3'b011, 32'h500, '0, 0);
    checks++;
    if (timed_out || stall_cycles != 0 || res_rde !== 1'b0 || obs_addr.size() != 0) begin
      errors++;
      $display("FAIL illegal_ld: got stall=%0d rdE=%b reqs=%0d expected 0 0 0",
               stall_cycles, res_rde, obs_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      bit          is_ld;
      logic [2:0]  f3;
      logic [31:0] addr, sd, want;
      int          n, dly;
      bit          bad;
      is_ld = 1'($urandom);
      f3    = {is_ld ? 1'($urandom) : 1'b0, 2'($urandom_range(0, 2))};
      n     = 1 << f3[1:0];
      addr  = 32'h400 + 32'($urandom_range(0, 255));
`ifdef MEM_MISALIGN_CHECK_EN
      addr  = addr & ~(32'(n) - 32'd1);
`endif
      if (k == 0) addr = 32'hFFFF_FFFE;
      sd    = $urandom;
      dly   = $urandom_range(0, 2);
      want  = exp_load(addr, f3);
      run_op(is_ld, !is_ld, f3, addr, sd, dly);
      bad = (obs_addr.size() != n);
      for (int i = 0; i < obs_addr.size() && i < n; i++) begin
        if (obs_addr[i] !== addr + 32'(i)) bad = 1'b1;
        if (!is_ld && mem_model[addr + 32'(i)] !== sd[8*i +: 8]) bad = 1'b1;
      end
      checks++;
      if (timed_out || bad || wait_bad != 0 || stall_cycles != n + 1 + n * dly) begin
        errors++;
        $display("FAIL rand_access[%0d]: got reqs=%0d stall=%0d unstable=%0d expected reqs=%0d stall=%0d ld=%b addr=%h",
                 k, obs_addr.size(), stall_cycles, wait_bad, n, n + 1 + n * dly, is_ld, addr);
      end
      checks++;
      if (is_ld ? (res_data !== want || res_rde !== 1'b1) : (res_rde !== 1'b0)) begin
        errors++;
        $display("FAIL rand_result[%0d]: got data=%h rdE=%b expected data=%h rdE=%b f3=%b",
                 k, res_data, res_rde, is_ld ? want : 32'h0, is_ld, f3);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sw();
    test_lw_delay();
    test_reset_mid();
    test_misalign();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
